gray_exe_ctrl: RTL and testbench

Sequencing and arbitration controller for the SPI execution unit's Gray-code encoder. It accepts signed operands from two requesters, the SPI command decoder (port A) and the register-readback path (port B). Requesters are served round-robin, one operand at a time, through a single shared encoder instance. Each result is registered together with its source tag and an error flag, and is held until the downstream SPI transmit stage accepts it.

---
 rtl/gray_exe_pkg.sv | 8 +
 rtl/gray_koder2.sv | 11 +
 rtl/gray_exe_ctrl.sv | 94 +++++++++
 tb/tb_gray_exe_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/gray_exe_pkg.sv
// gray_exe_pkg: shared types and constants for the Gray-code execution controller
package gray_exe_pkg;
  typedef enum logic [1:0] {IDLE, CODE, RESP} gray_exe_state_t;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;
  localparam int DEF_LEN = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/gray_koder2.sv
// gray_koder2: combinational Gray encoder; negative operands saturate to all ones with an error flag
module gray_koder2 #(
  parameter int LEN = 4
) (
  input  logic [LEN-1:0] i_data,
  output logic [LEN-1:0] o_res,
  output logic           o_err
);
  assign o_err = i_data[LEN-1];
  assign o_res = o_err ? '1 : i_data ^ (i_data >> 1);
endmodule

// File: rtl/gray_exe_ctrl.sv
// gray_exe_ctrl: round-robin arbiter and IDLE/CODE/RESP sequencer around one shared Gray encoder
module gray_exe_ctrl
  import gray_exe_pkg::*;
#(
  parameter int LEN = DEF_LEN,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_val_a,
  input  logic [LEN-1:0]   i_data_a,
  output logic             o_rdy_a,
  input  logic             i_val_b,
  input  logic [LEN-1:0]   i_data_b,
  output logic             o_rdy_b,
  output logic [LEN-1:0]   o_res,
  output logic             o_res_src,
  output logic             o_res_err,
  output logic             o_res_val,
  input  logic             i_res_rdy,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_err_cnt
);
  gray_exe_state_t state_q, state_d;
  logic ptr_q, ptr_d, src_q, src_d, res_src_q, res_src_d, res_err_q, res_err_d;
  logic [LEN-1:0] data_q, data_d, res_q, res_d, enc_res;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic enc_err, idle, gnt_a, gnt_b;
  assign idle = state_q == IDLE;
  // A lone requester always wins; the pointer only breaks ties
  assign gnt_a = i_val_a & (~i_val_b | ptr_q == SRC_A);
  assign gnt_b = i_val_b & ~gnt_a;
  assign o_rdy_a = idle & ~i_rst & gnt_a;
  assign o_rdy_b = idle & ~i_rst & gnt_b;
  assign o_res = res_q;
  assign o_res_src = res_src_q;
  assign o_res_err = res_err_q;
  assign o_res_val = state_q == RESP;
  assign o_busy = ~idle;
  assign o_err_cnt = err_cnt_q;
  gray_koder2 #(.LEN(LEN)) u_enc (
    .i_data(data_q),
    .o_res (enc_res),
    .o_err (enc_err)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    src_d = src_q;
    data_d = data_q;
    res_d = res_q;
    res_src_d = res_src_q;
    res_err_d = res_err_q;
    err_cnt_d = err_cnt_q;
    unique case (state_q)
      IDLE: if (gnt_a | gnt_b) begin
        state_d = CODE;
        data_d = gnt_b ? i_data_b : i_data_a;
        src_d = gnt_b ? SRC_B : SRC_A;
        ptr_d = gnt_b ? SRC_A : SRC_B;
      end
      CODE: begin
        state_d = RESP;
        res_d = enc_res;
        res_err_d = enc_err;
        res_src_d = src_q;
        err_cnt_d = (enc_err && ~&err_cnt_q) ? err_cnt_q + CNT_W'(1) : err_cnt_q;
      end
      RESP: state_d = i_res_rdy ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q <= SRC_A;
      src_q <= SRC_A;
      data_q <= '0;
      res_q <= '0;
      res_src_q <= 1'b0;
      res_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      src_q <= src_d;
      data_q <= data_d;
      res_q <= res_d;
      res_src_q <= res_src_d;
      res_err_q <= res_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end
endmodule

// File: tb/tb_gray_exe_ctrl.sv
// tb_gray_exe_ctrl: directed stimulus with a result scoreboard checked by an independent monitor
module tb_gray_exe_ctrl;
  typedef struct packed {
    logic [3:0] res;
    logic       src;
    logic       err;
  } exp_t;

  logic i_clk, i_rst, i_val_a, i_val_b, i_res_rdy;
  logic [3:0] i_data_a, i_data_b;
  logic o_rdy_a, o_rdy_b, o_res_src, o_res_err, o_res_val, o_busy;
  logic [3:0] o_res;
  logic [7:0] o_err_cnt;
  int checks = 0;
  int errors = 0;
  exp_t q[$];

  gray_exe_ctrl #(.LEN(4), .CNT_W(8)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_val_a(i_val_a), .i_data_a(i_data_a), .o_rdy_a(o_rdy_a),
    .i_val_b(i_val_b), .i_data_b(i_data_b), .o_rdy_b(o_rdy_b),
    .o_res(o_res), .o_res_src(o_res_src), .o_res_err(o_res_err),
    .o_res_val(o_res_val), .i_res_rdy(i_res_rdy),
    .o_busy(o_busy), .o_err_cnt(o_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", n, a, x, $time);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (!i_rst && o_res_val && i_res_rdy) begin
      if (q.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        chk("res", o_res, e.res);
        chk("res_src", o_res_src, e.src);
        chk("res_err", o_res_err, e.err);
      end
    end
    if (!i_rst) chk("rdy_onehot", o_rdy_a & o_rdy_b, 0);
  end

  task automatic expect_res(input bit b, input logic [3:0] r, input bit e);
    q.push_back(exp_t'{res: r, src: b, err: e});
  endtask

  task automatic send(input bit b, input logic [3:0] d, input logic [3:0] r, input bit e);
    int n = 0;
    expect_res(b, r, e);
    if (b) begin i_val_b = 1'b1; i_data_b = d; end
    else begin i_val_a = 1'b1; i_data_a = d; end
    @(negedge i_clk);
    while (!(b ? o_rdy_b : o_rdy_a) && n < 50) begin n++; @(negedge i_clk); end
    if (n >= 50) chk("rdy_timeout", 0, 1);
    @(posedge i_clk); #1;
    if (b) i_val_b = 1'b0; else i_val_a = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || o_busy) && n < 100) begin n++; @(negedge i_clk); end
    if (n >= 100) chk("drain_timeout", 0, 1);
    @(posedge i_clk); #1;
  endtask

  task automatic check_zero(input string n);
    chk({n, "_res"}, {o_res, o_res_src, o_res_err, o_res_val}, 0);
    chk({n, "_busy"}, o_busy, 0);
    chk({n, "_cnt"}, o_err_cnt, 0);
    chk({n, "_rdy"}, {o_rdy_a, o_rdy_b}, 0);
  endtask

  initial begin
    i_rst = 1'b1; i_val_a = 1'b0; i_val_b = 1'b0;
    i_data_a = '0; i_data_b = '0; i_res_rdy = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_val_a = 1'b1; i_val_b = 1'b1;
    @(negedge i_clk);
    check_zero("reset");
    @(posedge i_clk); #1;
    i_val_a = 1'b0; i_val_b = 1'b0; i_rst = 1'b0;
    @(posedge i_clk); #1;
    // positive operand with exact latency
    send(0, 4'd5, 4'b0111, 0);
    @(negedge i_clk);
    chk("pos_rdy_single", o_rdy_a, 0);
    chk("pos_code_val", o_res_val, 0);
    chk("pos_code_busy", o_busy, 1);
    @(negedge i_clk);
    chk("pos_resp_val", o_res_val, 1);
    chk("pos_resp_res", o_res, 4'b0111);
    drain();
    // negative operand from B
    send(1, 4'b1010, 4'b1111, 1);
    drain();
    chk("neg_cnt", o_err_cnt, 1);
    // simultaneous requests after reset start with A and alternate
    i_rst = 1'b1; #1 i_rst = 1'b0;
    @(posedge i_clk); #1;
    expect_res(0, 4'b0010, 0); expect_res(1, 4'b0101, 0);
    expect_res(0, 4'b0010, 0); expect_res(1, 4'b0101, 0);
    i_val_a = 1'b1; i_data_a = 4'd3; i_val_b = 1'b1; i_data_b = 4'd6;
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      @(negedge i_clk);
      while (!(o_rdy_a | o_rdy_b) && n < 50) begin n++; @(negedge i_clk); end
      if (n >= 50) chk("sim_timeout", 0, 1);
      chk("sim_grant_b", o_rdy_b, k % 2);
      @(posedge i_clk); #1;
    end
    i_val_a = 1'b0; i_val_b = 1'b0;
    drain();
    // backpressure stall
    i_res_rdy = 1'b0;
    send(0, 4'd6, 4'b0101, 0);
    @(posedge i_clk); #1;
    i_val_b = 1'b1; i_data_b = 4'd2;
    expect_res(1, 4'b0011, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      chk("bp_val", o_res_val, 1);
      chk("bp_res", o_res, 4'b0101);
      chk("bp_rdy", {o_rdy_a, o_rdy_b}, 0);
    end
    @(posedge i_clk); #1 i_res_rdy = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("bp_idle", o_busy, 0);
    chk("bp_rdy_b", o_rdy_b, 1);
    @(posedge i_clk); #1 i_val_b = 1'b0;
    drain();
    chk("bp_cnt", o_err_cnt, 0);
    // counter saturation
    for (int k = 0; k < 300; k++) send(0, 4'b1000, 4'b1111, 1);
    drain();
    chk("sat_cnt", o_err_cnt, 255);
    // reset during CODE
    i_val_a = 1'b1; i_data_a = 4'd5;
    @(negedge i_clk);
    chk("mid_rdy_a", o_rdy_a, 1);
    @(posedge i_clk); #1 i_val_a = 1'b0;
    chk("mid_busy", o_busy, 1);
    i_rst = 1'b1;
    #1 check_zero("mid_reset");
    i_val_a = 1'b1; i_data_a = 4'd5; i_val_b = 1'b1; i_data_b = 4'd6;
    @(negedge i_clk);
    chk("mid_rst_rdy", {o_rdy_a, o_rdy_b}, 0);
    expect_res(0, 4'b0111, 0); expect_res(1, 4'b0101, 0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    chk("mid_ptr_a", {o_rdy_a, o_rdy_b}, 2'b10);
    @(posedge i_clk); #1 i_val_a = 1'b0;
    begin
      int n = 0;
      @(negedge i_clk);
      while (!o_rdy_b && n < 50) begin n++; @(negedge i_clk); end
      if (n >= 50) chk("mid_b_timeout", 0, 1);
    end
    @(posedge i_clk); #1 i_val_b = 1'b0;
    drain();
    chk("mid_cnt", o_err_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
